// File: rtl/fib_pkg.sv
// Shared definitions for the Fibonacci generator and its stream checker:
// checker state encoding and the default seed terms.
package fib_pkg;

    typedef enum logic [1:0] {
        SEED0,
        SEED1,
        RUN,
        DONE
    } fib_chk_state_t;

    localparam int unsigned FIB_SEED0 = 0;
    localparam int unsigned FIB_SEED1 = 1;

endpackage

// File: rtl/fib_checker.sv
// Consumer-side checker for the fib generator stream: verifies each term against
// the two before it, counts terms, captures the first failure and gives a verdict.
module fib_checker #(
    parameter int               WIDTH       = 32,
    parameter logic [WIDTH-1:0] SEED0       = WIDTH'(fib_pkg::FIB_SEED0),
    parameter logic [WIDTH-1:0] SEED1       = WIDTH'(fib_pkg::FIB_SEED1),
    parameter bit               CHECK_SEEDS = 1'b1,
    parameter int               CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] fib,
    input  logic             fib_valid,
    input  logic             fib_finish,
    input  logic [CNT_W-1:0] n_terms,
    output logic [CNT_W-1:0] term_cnt,
    output logic             err,
    output logic [CNT_W-1:0] err_idx,
    output logic [WIDTH-1:0] err_exp,
    output logic [WIDTH-1:0] err_act,
    output logic             ovf,
    output logic             done,
    output logic             pass
);
    import fib_pkg::*;

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    fib_chk_state_t   state;
    logic [WIDTH-1:0] p1, p2;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] exp_val;
    logic             accept, checked, mismatch, err_now, count_bad;
    logic [CNT_W-1:0] cnt_next;

    always_comb begin
        sum     = {1'b0, p2} + {1'b0, p1};
        exp_val = sum[WIDTH-1:0];
        checked = 1'b1;
        case (state)
            fib_pkg::SEED0: begin
                exp_val = SEED0;
                checked = CHECK_SEEDS;
            end
            fib_pkg::SEED1: begin
                exp_val = SEED1;
                checked = CHECK_SEEDS;
            end
            default: ;
        endcase
        accept    = fib_valid && (state != DONE);
        mismatch  = accept && checked && (fib != exp_val);
        cnt_next  = (accept && (term_cnt != '1)) ? term_cnt + CNT_ONE : term_cnt;
        err_now   = err || mismatch;
        // The count check uses the count including a term accepted this same cycle.
        count_bad = (n_terms != '0) && (cnt_next != n_terms);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= fib_pkg::SEED0;
            p1       <= '0;
            p2       <= '0;
            term_cnt <= '0;
            err      <= 1'b0;
            err_idx  <= '0;
            err_exp  <= '0;
            err_act  <= '0;
            ovf      <= 1'b0;
            done     <= 1'b0;
            pass     <= 1'b0;
        end else begin
            term_cnt <= cnt_next;
            if (accept) begin
                case (state)
                    fib_pkg::SEED0: begin
                        p2    <= fib;
                        state <= fib_pkg::SEED1;
                    end
                    fib_pkg::SEED1: begin
                        p1    <= fib;
                        state <= RUN;
                    end
                    default: begin
                        // Shift in the received term so one bad term cannot poison the rest.
                        p2 <= p1;
                        p1 <= fib;
                        if (sum[WIDTH])
                            ovf <= 1'b1;
                    end
                endcase
            end
            if (mismatch) begin
                err <= 1'b1;
                if (!err) begin
                    err_idx <= term_cnt;
                    err_exp <= exp_val;
                    err_act <= fib;
                end
            end
            if (fib_finish && (state != DONE)) begin
                state <= DONE;
                done  <= 1'b1;
                pass  <= !(err_now || count_bad);
                if (count_bad) begin
                    err <= 1'b1;
                    if (!err_now) begin
                        err_idx <= cnt_next;
                        err_exp <= WIDTH'(n_terms);
                        err_act <= WIDTH'(cnt_next);
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_fib_checker.sv
// Scoreboard bench for fib_checker: three instances (default, 8-bit, unchecked seeds)
// driven one at a time, with a behavioural model queueing expected outputs per cycle.
module tb_fib_checker;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] fib_in;
    logic        valid_in, finish_in;
    logic [15:0] n_in;
    int          sel;

    always #5 clk = ~clk;

    logic [15:0] a_cnt, b_cnt, c_cnt, a_idx, b_idx, c_idx;
    logic [31:0] a_eexp, a_eact, c_eexp, c_eact;
    logic [7:0]  b_eexp, b_eact;
    logic        a_err, b_err, c_err, a_ovf, b_ovf, c_ovf;
    logic        a_done, b_done, c_done, a_pass, b_pass, c_pass;

    fib_checker u_a (
        .clk(clk), .rst_n(rst_n), .fib(fib_in),
        .fib_valid(valid_in && sel == 0), .fib_finish(finish_in && sel == 0),
        .n_terms(n_in), .term_cnt(a_cnt), .err(a_err), .err_idx(a_idx),
        .err_exp(a_eexp), .err_act(a_eact), .ovf(a_ovf), .done(a_done), .pass(a_pass)
    );

    fib_checker #(.WIDTH(8)) u_b (
        .clk(clk), .rst_n(rst_n), .fib(fib_in[7:0]),
        .fib_valid(valid_in && sel == 1), .fib_finish(finish_in && sel == 1),
        .n_terms(n_in), .term_cnt(b_cnt), .err(b_err), .err_idx(b_idx),
        .err_exp(b_eexp), .err_act(b_eact), .ovf(b_ovf), .done(b_done), .pass(b_pass)
    );

    fib_checker #(.CHECK_SEEDS(1'b0)) u_c (
        .clk(clk), .rst_n(rst_n), .fib(fib_in),
        .fib_valid(valid_in && sel == 2), .fib_finish(finish_in && sel == 2),
        .n_terms(n_in), .term_cnt(c_cnt), .err(c_err), .err_idx(c_idx),
        .err_exp(c_eexp), .err_act(c_eact), .ovf(c_ovf), .done(c_done), .pass(c_pass)
    );

    logic [15:0] obs_cnt, obs_idx;
    logic [31:0] obs_eexp, obs_eact;
    logic        obs_err, obs_ovf, obs_done, obs_pass;

    always_comb begin
        obs_cnt = a_cnt; obs_idx = a_idx; obs_eexp = a_eexp; obs_eact = a_eact;
        obs_err = a_err; obs_ovf = a_ovf; obs_done = a_done; obs_pass = a_pass;
        if (sel == 1) begin
            obs_cnt = b_cnt; obs_idx = b_idx; obs_eexp = {24'd0, b_eexp}; obs_eact = {24'd0, b_eact};
            obs_err = b_err; obs_ovf = b_ovf; obs_done = b_done; obs_pass = b_pass;
        end else if (sel == 2) begin
            obs_cnt = c_cnt; obs_idx = c_idx; obs_eexp = c_eexp; obs_eact = c_eact;
            obs_err = c_err; obs_ovf = c_ovf; obs_done = c_done; obs_pass = c_pass;
        end
    end

    typedef struct {
        logic [15:0] cnt;
        logic        err;
        logic [15:0] idx;
        logic [31:0] eexp;
        logic [31:0] eact;
        logic        ovf;
        logic        done;
        logic        pass;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   step     = 0;

    int              m_state, m_width;
    bit              m_check, m_err, m_ovf, m_done, m_pass;
    longint unsigned m_p1, m_p2, m_eexp, m_eact;
    int unsigned     m_cnt, m_idx;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        if (obs !== expv) begin
            n_fail++;
            $display("[TB] FAIL %s: observed %0d, expected %0d", tag, obs, expv);
        end
    endtask

    task automatic pushExpected();
        exp_t e;
        e.cnt  = m_cnt[15:0];
        e.err  = m_err;
        e.idx  = m_idx[15:0];
        e.eexp = m_eexp[31:0];
        e.eact = m_eact[31:0];
        e.ovf  = m_ovf;
        e.done = m_done;
        e.pass = m_pass;
        exp_q.push_back(e);
    endtask

    task automatic popAndCheck();
        exp_t e;
        string p;
        e = exp_q.pop_front();
        step++;
        p = $sformatf("s%0d_", step);
        checkOutput({p, "term_cnt"}, {16'd0, obs_cnt}, {16'd0, e.cnt});
        checkOutput({p, "err"}, {31'd0, obs_err}, {31'd0, e.err});
        checkOutput({p, "err_idx"}, {16'd0, obs_idx}, {16'd0, e.idx});
        checkOutput({p, "err_exp"}, obs_eexp, e.eexp);
        checkOutput({p, "err_act"}, obs_eact, e.eact);
        checkOutput({p, "ovf"}, {31'd0, obs_ovf}, {31'd0, e.ovf});
        checkOutput({p, "done"}, {31'd0, obs_done}, {31'd0, e.done});
        checkOutput({p, "pass"}, {31'd0, obs_pass}, {31'd0, e.pass});
    endtask

    task automatic captureFirst(input int unsigned idx, input longint unsigned ev, input longint unsigned av);
        if (!m_err) begin
            m_idx  = idx;
            m_eexp = ev;
            m_eact = av;
        end
        m_err = 1'b1;
    endtask

    // Behavioural reference: Fibonacci recurrence with seeds 0/1 modulo 2^m_width.
    task automatic modelStep(input bit v, input logic [31:0] val, input bit fin);
        longint unsigned mask, vv, sum, expv;
        bit chk;
        mask = (64'd1 << m_width) - 1;
        vv   = {32'd0, val} & mask;
        if (!m_done) begin
            if (v) begin
                chk  = 1'b1;
                expv = 0;
                if (m_state == 0) begin
                    expv = 0; chk = m_check; m_p2 = vv; m_state = 1;
                end else if (m_state == 1) begin
                    expv = 1; chk = m_check; m_p1 = vv; m_state = 2;
                end else begin
                    sum  = m_p2 + m_p1;
                    expv = sum & mask;
                    if (sum > mask) m_ovf = 1'b1;
                    m_p2 = m_p1;
                    m_p1 = vv;
                end
                if (chk && vv != expv) captureFirst(m_cnt, expv, vv);
                if (m_cnt < 65535) m_cnt++;
            end
            if (fin) begin
                m_done = 1'b1;
                if (n_in != 0 && m_cnt != n_in)
                    captureFirst(m_cnt, n_in & mask, m_cnt & mask);
                m_pass = !m_err;
            end
        end
    endtask

    task automatic applyStimulus(input bit v, input logic [31:0] val, input bit fin);
        valid_in  = v;
        fib_in    = val;
        finish_in = fin;
        modelStep(v, val, fin);
        pushExpected();
        @(posedge clk);
        #1;
        popAndCheck();
    endtask

    task automatic resetAll(input int s);
        sel       = s;
        rst_n     = 1'b0;
        valid_in  = 1'b0;
        finish_in = 1'b0;
        fib_in    = '0;
        m_state = 0; m_width = (s == 1) ? 8 : 32; m_check = (s != 2);
        m_err = 0; m_ovf = 0; m_done = 0; m_pass = 0;
        m_p1 = 0; m_p2 = 0; m_eexp = 0; m_eact = 0; m_cnt = 0; m_idx = 0;
        pushExpected();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        popAndCheck();
    endtask

    int fib10[10] = '{0, 1, 1, 2, 3, 5, 8, 13, 21, 34};
    int fib8[15]  = '{0, 1, 1, 2, 3, 5, 8, 13, 21, 34, 55, 89, 144, 233, 121};
    int lucas[5]  = '{2, 1, 3, 4, 7};

    initial begin
        n_in = 16'd10;
        resetAll(0);
        foreach (fib10[i]) applyStimulus(1'b1, fib10[i], 1'b0);
        applyStimulus(1'b0, 0, 1'b1);
        checkOutput("t1_pass", {31'd0, a_pass}, 32'd1);
        checkOutput("t1_cnt", {16'd0, a_cnt}, 32'd10);
        applyStimulus(1'b1, 55, 1'b0);

        resetAll(0);
        foreach (fib10[i]) applyStimulus(1'b1, (i == 5) ? 6 : fib10[i], 1'b0);
        applyStimulus(1'b0, 0, 1'b1);
        checkOutput("t2_idx", {16'd0, a_idx}, 32'd5);
        checkOutput("t2_exp", a_eexp, 32'd5);
        checkOutput("t2_act", a_eact, 32'd6);
        checkOutput("t2_pass", {31'd0, a_pass}, 32'd0);

        n_in = 16'd0;
        resetAll(1);
        foreach (fib8[i]) applyStimulus(1'b1, fib8[i], 1'b0);
        applyStimulus(1'b0, 0, 1'b1);
        checkOutput("t3_ovf", {31'd0, b_ovf}, 32'd1);
        checkOutput("t3_err", {31'd0, b_err}, 32'd0);

        n_in = 16'd12;
        resetAll(0);
        foreach (fib10[i]) applyStimulus(1'b1, fib10[i], i == 9);
        checkOutput("t4_idx", {16'd0, a_idx}, 32'd10);
        checkOutput("t4_exp", a_eexp, 32'd12);
        checkOutput("t4_act", a_eact, 32'd10);

        n_in = 16'd0;
        resetAll(0);
        applyStimulus(1'b1, 0, 1'b0);
        applyStimulus(1'b1, 1, 1'b0);
        applyStimulus(1'b1, 1, 1'b0);
        applyStimulus(1'b1, 5, 1'b0);
        checkOutput("t5_err", {31'd0, a_err}, 32'd1);
        resetAll(0);
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, fib10[i], 1'b0);
        applyStimulus(1'b0, 0, 1'b0);

        n_in = 16'd5;
        resetAll(2);
        foreach (lucas[i]) applyStimulus(1'b1, lucas[i], 1'b0);
        applyStimulus(1'b0, 0, 1'b1);
        checkOutput("t6_pass", {31'd0, c_pass}, 32'd1);

        n_in = 16'd3;
        resetAll(0);
        applyStimulus(1'b0, 0, 1'b1);
        n_in = 16'd0;
        resetAll(0);
        applyStimulus(1'b0, 0, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fib_checker.md
# fib_checker

Stream checker sitting on the consumer end of the `fib` generator interface: it samples each Fibonacci term the generator emits and verifies it against the two preceding terms. It also counts terms and reports a sticky error with diagnostic capture. When the generator raises its finish flag, the checker produces a registered pass/fail verdict. It is synthesizable and lives beside `fib` in the lab datapath so self-checking runs need no testbench arithmetic.

## Interface
- `WIDTH`, 32, data width of terms; all arithmetic is mod 2^WIDTH.
- `SEED0`, 0, required value of term 0.
- `SEED1`, 1, required value of term 1.
- `CHECK_SEEDS`, 1, when 1 terms 0/1 are compared to SEED0/SEED1; when 0 they are accepted as-is.
- `CNT_W`, 16, width of term counter / index outputs.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `fib`  in  WIDTH  term from generator.
- `fib_valid`  in  1  `fib` holds a new term this cycle.
- `fib_finish`  in  1  generator has emitted its last term (level).
- `n_terms`  in  CNT_W  expected total term count; 0 disables the count check.
- `term_cnt`  out  CNT_W  terms accepted so far, saturating.
- `err`  out  1  sticky mismatch/count error.
- `err_idx`  out  CNT_W  index of first failing term.
- `err_exp`  out  WIDTH  expected value at first failure.
- `err_act`  out  WIDTH  received value at first failure.
- `ovf`  out  1  sticky: some true sum exceeded 2^WIDTH-1.
- `done`  out  1  verdict valid; held until reset.
- `pass`  out  1  meaningful when `done`: `!err`.

## Operation
- States: SEED0 -> SEED1 -> RUN -> DONE. Reset enters SEED0.
- SEED0, on `fib_valid`:
  - store term in `p2`;
  - check vs SEED0 if CHECK_SEEDS;
  - go to SEED1.
- SEED1, on `fib_valid`:
  - store in `p1`;
  - check vs SEED1;
  - go to RUN.
- RUN, on `fib_valid`:
  - `exp = p2 + p1` (WIDTH+1-bit sum, low WIDTH compared);
  - carry-out sets `ovf`;
  - mismatch sets `err`;
  - shift `p2 <= p1`, `p1 <= fib` (received value, not expected, so one bad term produces at most the two follow-on mismatches and recovery is observable).
- Every accepted term increments `term_cnt`, saturating at 2^CNT_W-1.
- First error only: latch `err_idx` = `term_cnt` before increment, plus `err_exp` and `err_act`. Later errors leave captures untouched.
- `fib_finish` in any state other than DONE goes to DONE.
- On entering DONE: if `n_terms != 0` and the final count (including a term accepted the same cycle) `!= n_terms`, set `err`. If no prior capture exists, latch `err_idx` = final count, `err_exp` = `n_terms` zero-extended, and `err_act` = final count zero-extended.
- In DONE, `fib_valid` and `fib_finish` are ignored.

## Timing
- All outputs are registered. Reset values: `term_cnt`=0, `err`=0, `err_idx`=0, `err_exp`=0, `err_act`=0, `ovf`=0, `done`=0, `pass`=0.
- A term sampled at edge k is reflected in `term_cnt`/`err`/`ovf` after edge k (visible in cycle k+1).
- `fib_valid` and `fib_finish` in the same cycle: the term is checked and counted first, then DONE is entered. `done`/`pass` rise after that same edge and include that term.
- `fib_finish` before any term gives DONE with `term_cnt`=0. The verdict then depends only on `n_terms`.
- `rst_n` low mid-run clears everything at the next edge, including sticky flags and captures.
- No back-pressure: the checker accepts `fib_valid` every cycle.

## Structure
- Shared package `fib_pkg`:
  - state enum `fib_chk_state_t` {SEED0, SEED1, RUN, DONE};
  - default seed constants, used by `fib` and `fib_checker` alike.
- Single module, no sub-module. The WIDTH+1 adder is inline.

## Test plan
- Reset, 10 valid terms 0,1,1,2,3,5,8,13,21,34, finish with `n_terms`=10 -> `done`=1, `pass`=1, `term_cnt`=10, `ovf`=0.
- Same stream with term 5 = 6 -> `err`=1 latched the cycle after term 5, `err_idx`=5, `err_exp`=5, `err_act`=6. Finish gives `pass`=0 and captures unchanged.
- WIDTH=8, terms run to 233 then 121 (377 mod 256) -> no `err`, `ovf`=1 after that term.
- Correct 10-term stream, `n_terms`=12, `fib_finish` concurrent with the 10th `fib_valid` -> `term_cnt`=10, `err`=1, `err_idx`=10, `err_exp`=12, `err_act`=10, `done` rises after that edge.
- `rst_n` low for one cycle after term 4 with `err` set -> all outputs 0 next cycle. Fresh stream 0,1,1 is checked from SEED0 with no error.
- CHECK_SEEDS=0, stream 2,1,3,4,7 -> `pass`=1 (Lucas seeds accepted).
